// File: rtl/rtc_update_sequencer_if.sv
// Handshake and register-file bundle between the RTC update sequencer and
// its environment: the edit-counter register files, the RTC write driver
// and the run controller.
interface rtc_update_sequencer_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          iniciar;
  logic          fin;
  logic [DW-1:0] dato;
  logic [DW-1:0] dato_up;
  logic [DW-1:0] dato_down;
  logic [AW-1:0] addr;
  logic [7:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          escribe;
  logic          erase;
  logic [AW-1:0] erase_idx;
  logic          busy;
  logic          final_pulse;  // end-of-sweep strobe ("final" is a reserved word)
  logic          err;

  // Sequencer side
  modport master (
    input  iniciar, fin, dato, dato_up, dato_down,
    output addr, wr_addr, wr_data, escribe, erase, erase_idx, busy,
           final_pulse, err
  );

  // Environment side: register files, bus driver, run controller
  modport slave (
    output iniciar, fin, dato, dato_up, dato_down,
    input  addr, wr_addr, wr_data, escribe, erase, erase_idx, busy,
           final_pulse, err
  );
endinterface

// File: rtl/rtc_update_sequencer.sv
// Sweeps a range of RTC shadow-register indices, applies the pending up/down
// edits (dato + up - down, wrapped or saturated), writes each result to the
// RTC bus driver with a fin handshake, then clears that index's edit counters.
module rtc_update_sequencer #(
  parameter int            DW             = 8,
  parameter int            AW             = 4,
  parameter int            N_REGS         = 10,
  parameter int            FIRST_IDX      = 1,
  parameter int            SPLIT_IDX      = 8,
  parameter logic [7:0]    ADDR_LO_BASE   = 8'h20,
  parameter logic [7:0]    ADDR_HI_BASE   = 8'h41,
  parameter bit            SATURATE       = 1'b0,
  parameter logic [DW-1:0] MAX_VAL        = '1,
  parameter bit            SKIP_UNCHANGED = 1'b0,
  parameter int            TIMEOUT        = 255
) (
  input logic                   clk,
  input logic                   reset,
  rtc_update_sequencer_if.master bus
);

  localparam int            TW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] FIRST_A = AW'(FIRST_IDX);
  localparam logic [AW-1:0] LAST_A  = AW'(FIRST_IDX + N_REGS - 1);
  localparam logic [AW-1:0] SPLIT_A = AW'(SPLIT_IDX);
  localparam logic [7:0]    SPLIT_8 = 8'(SPLIT_IDX);
  localparam logic [DW+1:0] MAX_EXT = {2'b00, MAX_VAL};

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CALC, S_WRITE, S_ERASE, S_NEXT, S_DONE, S_HOLD
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] addr_reg;
  logic [7:0]    wr_addr_reg;
  logic [DW-1:0] wr_data_reg;
  logic          err_reg;
  logic [TW-1:0] tmo_reg;

  logic signed [DW+1:0] sum;
  logic [DW-1:0]        calc_data;
  logic [7:0]           calc_addr;
  logic [7:0]           idx8;
  logic                 timeout_hit;
  logic                 is_busy;

  // Edit arithmetic and bank-split address mapping for the current index
  always_comb begin
    sum = $signed({2'b00, bus.dato}) + $signed({2'b00, bus.dato_up})
        - $signed({2'b00, bus.dato_down});
    calc_data = sum[DW-1:0];
    if (SATURATE) begin
      if (sum[DW+1]) begin
        calc_data = '0;
      end else if ($unsigned(sum) > MAX_EXT) begin
        calc_data = MAX_VAL;
      end
    end
    idx8 = 8'(addr_reg);
    if (addr_reg < SPLIT_A) begin
      calc_addr = ADDR_LO_BASE + idx8;
    end else begin
      calc_addr = ADDR_HI_BASE + (idx8 - SPLIT_8);
    end
    // counter holds the number of completed WRITE cycles, so this is the
    // TIMEOUT-th consecutive cycle without fin
    timeout_hit = (TIMEOUT != 0) && (tmo_reg == TW'(TIMEOUT - 1));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and output decode
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.iniciar) state_next = S_ADDR;
      S_ADDR:  state_next = S_CALC;
      S_CALC:  state_next = (SKIP_UNCHANGED && (bus.dato_up == bus.dato_down))
                            ? S_NEXT : S_WRITE;
      S_WRITE: begin
        if (bus.fin) begin
          state_next = S_ERASE;
        end else if (timeout_hit) begin
          state_next = S_DONE;
        end
      end
      S_ERASE: state_next = S_NEXT;
      S_NEXT:  state_next = (addr_reg == LAST_A) ? S_DONE : S_ADDR;
      S_DONE:  state_next = S_HOLD;
      S_HOLD:  if (!bus.iniciar) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // dropping the run request aborts a sweep in progress
    if (!bus.iniciar && (state != S_IDLE) && (state != S_HOLD)) begin
      state_next = S_IDLE;
    end

    is_busy         = (state != S_IDLE) && (state != S_HOLD);
    bus.busy        = is_busy;
    bus.addr        = is_busy ? addr_reg : '0;
    bus.escribe     = (state == S_WRITE);
    bus.wr_addr     = (state == S_WRITE) ? wr_addr_reg : 8'h00;
    bus.wr_data     = (state == S_WRITE) ? wr_data_reg : '0;
    bus.erase       = (state == S_ERASE);
    bus.erase_idx   = (state == S_ERASE) ? addr_reg : '0;
    // gated by iniciar so an abort in DONE never shows an end-of-sweep pulse
    bus.final_pulse = (state == S_DONE) && bus.iniciar;
    bus.err         = err_reg;
  end

  // Index, write latches, timeout counter and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg    <= '0;
      wr_addr_reg <= 8'h00;
      wr_data_reg <= '0;
      err_reg     <= 1'b0;
      tmo_reg     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (state_next == S_ADDR) begin
            addr_reg <= FIRST_A;
            err_reg  <= 1'b0;
            tmo_reg  <= '0;
          end
        end
        S_CALC: begin
          wr_addr_reg <= calc_addr;
          wr_data_reg <= calc_data;
          tmo_reg     <= '0;
        end
        S_WRITE: begin
          if (state_next == S_DONE) begin
            err_reg <= 1'b1;
          end else if (state_next == S_WRITE) begin
            tmo_reg <= tmo_reg + TW'(1);
          end
        end
        S_NEXT: begin
          if (state_next == S_ADDR) addr_reg <= addr_reg + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
